// File: rtl/d_sram_axi_bridge_if.sv
// AXI3 bus bundle between the cache bridge and the system crossbar.
// Holds all five AXI channels (AR, R, AW, W, B).
//   master modport: the bridge side. It drives the address, write-data and
//                   ready signals.
//   slave  modport: the crossbar/slave side. It drives the read-data,
//                   response and ready signals.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1. The source holds valid and its
// payload stable until that edge. Ready may rise or fall at any time.
interface d_sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/d_sram_axi_bridge.sv
// Data-cache sram-like port to AXI3 master bridge.
// The bridge handles one transaction at a time, each a single beat.
// Write byte strobes are derived from the request size and the low
// address bits.
// Ports:
//   clk, rst      clock; asynchronous reset, active low
//   data_req/wr/size/addr/wdata   cache request; held by the cache until
//                                 addr_ok is returned
//   data_addr_ok  request accepted this cycle (IDLE only)
//   data_data_ok  one-cycle completion pulse
//   data_rdata    last read data; holds until the next read completes
//   bus_err       sticky flag, set by a non-OKAY rresp or bresp
//   dbg_state     current FSM state, for observation
//   axi           AXI3 master side
module d_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        bus_err,
  output logic [2:0]  dbg_state,
  d_sram_axi_bridge_if.master axi
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_A  = 3'd1;
  localparam logic [2:0] RD_D  = 3'd2;
  localparam logic [2:0] WR_AW = 3'd3;
  localparam logic [2:0] WR_B  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_ok_q, data_ok_d;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  axsize;
  logic [3:0]  strb;

  // Size 3 is treated as a word access.
  assign axsize = (size_q == 2'd3) ? 2'd2 : size_q;

  always_comb begin
    strb = 4'b1111;
    case (size_q)
      2'd0:    strb = 4'b0001 << addr_q[1:0];
      2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d    = data_addr;
          size_d    = data_size;
          wdata_d   = data_wdata;
          wr_d      = data_wr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wr ? WR_AW : RD_A;
        end
      end
      RD_A: if (axi.arready) state_d = RD_D;
      RD_D: begin
        // arlen is 0, so any beat is the final one, whatever rlast says.
        if (axi.rvalid) begin
          rdata_d   = axi.rdata;
          data_ok_d = 1'b1;
          if (axi.rresp != 2'b00) bus_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_AW: begin
        // AW and W complete independently, possibly in the same cycle.
        aw_done_d = aw_done_q | axi.awready;
        w_done_d  = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (axi.bvalid) begin
          data_ok_d = 1'b1;
          if (axi.bresp != 2'b00) bus_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Gating with rst keeps addr_ok low for the whole time reset is held.
  assign data_addr_ok = rst & data_req & (state_q == IDLE);
  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;
  assign bus_err      = bus_err_q;
  assign dbg_state    = state_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, axsize};
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == RD_A);
  assign axi.rready  = (state_q == RD_D);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, axsize};
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (state_q == WR_AW) & ~aw_done_q;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state_q == WR_AW) & ~w_done_q;

  assign axi.bready  = (state_q == WR_B);
endmodule

// File: doc/d_sram_axi_bridge.md
Name: d_sram_axi_bridge

Overview:
- Converts the data cache's downstream sram-like port (req/wr/size/addr/wdata → addr_ok/data_ok/rdata) into an AXI3 master. The cache's outputs drive this block's `data_*` inputs.
- Sits between the write-back data cache and the system AXI crossbar.
- Handles one transaction at a time: single-beat reads, single-beat writes.
- Byte strobes are derived from size and address.

Parameters:
- AXI_ID, 4'd1, constant value driven on arid/awid/wid.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- data_req  in  1  cache request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word).
- data_addr  in  32  byte address.
- data_wdata  in  32  write data, in bus lane position.
- data_rdata  out  32  read data, valid when data_ok=1.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  transaction complete; one-cycle pulse.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI read address channel.
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data channel.
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI write address channel.
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data channel.
- wready  in  1
- bid/bresp/bvalid  in  4/2/1  AXI write response channel.
- bready  out  1
- bus_err  out  1  sticky; set on any rresp/bresp ≠ 0.

Behaviour:
- **Constants:**
  - arlen = awlen = 0.
  - arburst = awburst = 2'b01.
  - arsize = awsize = {1'b0, size_q}, with size 3 mapped to 2.
  - wlast = 1.
  - ids = AXI_ID.
- **FSM states:** IDLE, RD_A, RD_D, WR_AW (AW and W issued concurrently), WR_B.
- **IDLE:**
  - data_addr_ok = data_req (combinational, only in IDLE).
  - On data_req, latch addr, size, wdata and wr into *_q.
  - Next state: RD_A if wr=0, else WR_AW.
  - data_addr_ok = 0 in every other state; requests presented then are not accepted and must be held by the cache.
- **RD_A:** arvalid = 1, araddr = addr_q. On arready go to RD_D.
- **RD_D:** rready = 1.
  - On rvalid & rlast: capture rdata into data_rdata, pulse data_data_ok the next cycle, go to IDLE.
  - rvalid with rlast=0 cannot occur (arlen=0); treat as final beat anyway.
- **WR_AW:**
  - awvalid and wvalid both start at 1. Each drops independently once its own handshake completes (tracked by flags aw_done and w_done).
  - awaddr = addr_q; wdata = wdata_q.
  - Leave for WR_B when both handshakes are done; this includes AW and W completing in the same cycle, or in different cycles in either order.
- **WR_B:** bready = 1. On bvalid, pulse data_data_ok the next cycle and go to IDLE.
- **Completion latency:**
  - data_data_ok is registered: it is high exactly one cycle, one cycle after the R or B handshake.
  - A new request may be accepted in that same data_ok cycle, since the FSM is already in IDLE.
- **wstrb from size_q and addr_q[1:0]:**
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored).
  - size 2 or 3: 4'b1111.
- **Address:** araddr/awaddr carry the full 32-bit address unmodified.
- **Read data hold:** data_rdata holds its last captured value until the next read completes.
- **bus_err:**
  - Set when rresp ≠ 0 at the R handshake or bresp ≠ 0 at the B handshake.
  - Cleared only by reset.
  - An erroring transaction still completes normally with data_data_ok.
- **Reset (rst=0, asynchronous):**
  - state = IDLE; aw_done = w_done = 0.
  - All valid/ready outputs = 0; data_addr_ok (held 0 while rst=0), data_data_ok, bus_err = 0; data_rdata = 0; latched fields = 0.
  - Reset mid-transaction abandons it; the AXI slave must be reset by the same signal.
- **Stability:** all AXI outputs are driven only from registered *_q fields, so they stay stable while valid is high, as AXI requires.

Test Plan:
- Read word at 0x1FC0_0010; arready delayed 2 cycles; rdata = 0xDEAD_BEEF with rresp=0 one cycle later → addr_ok in the req cycle; arvalid held 3 cycles with araddr=0x1FC0_0010, arsize=2; data_ok one cycle after R handshake with data_rdata=0xDEAD_BEEF; bus_err=0.
- Byte write to 0x8000_0003 with wdata=0xAB00_0000 → awaddr=0x8000_0003, awsize=0, wstrb=4'b1000, wlast=1; data_ok one cycle after bvalid.
- Half write to 0x8000_0002; wready asserted 3 cycles after awready → awvalid drops after the AW handshake, wvalid held until wready, wstrb=4'b1100; exactly one data_ok.
- Back-to-back: read, then a write requested in the data_ok cycle → write accepted in that cycle; a second req presented while busy sees addr_ok=0 until IDLE.
- bresp=2'b10 on a write → data_ok still pulses; bus_err=1 and stays 1 through a later clean read.
- rst pulled low while in RD_D → arvalid, rready and data_ok go 0 immediately; state returns to IDLE; after release a new read completes normally.
